// File: rtl/dance_pkg.sv
// Shared types and helpers for the dance-game judging core.
package dance_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    JUDGE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/dance_lane_judge.sv
// One player's judging slice: press edge detect, hit mask and the
// saturating hit / miss / error-press counters.
module dance_lane_judge
  import dance_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 judge,
  input  logic                 close,
  input  logic                 load,
  input  logic [NUM_LANES-1:0] window,
  input  logic [NUM_LANES-1:0] btn,
  output logic [CNT_W-1:0]     hits,
  output logic [CNT_W-1:0]     misses,
  output logic [CNT_W-1:0]     errorpress
);

  logic [NUM_LANES-1:0] btn_q;
  logic [NUM_LANES-1:0] hit_mask;
  logic [NUM_LANES-1:0] press;
  logic [NUM_LANES-1:0] legal;
  logic [NUM_LANES-1:0] eff_mask;
  logic                 bad;

  // eff_mask folds in this cycle's legal presses so a press on the closing
  // beat still counts toward the outgoing window.
  always_comb begin
    press    = btn & ~btn_q;
    legal    = press & window & ~hit_mask;
    bad      = |(press & ~legal);
    eff_mask = hit_mask | legal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q      <= '1;
      hit_mask   <= '0;
      hits       <= '0;
      misses     <= '0;
      errorpress <= '0;
    end else begin
      btn_q <= btn;
      if (load) begin
        hit_mask <= '0;
      end else if (judge) begin
        hit_mask <= eff_mask;
      end
      if (judge && bad) begin
        errorpress <= CNT_W'(sat_inc(32'(errorpress), CNT_W));
      end
      // eff_mask is always a subset of window, so inequality means an unhit lane.
      if (close && (window != '0)) begin
        if (eff_mask == window) begin
          hits <= CNT_W'(sat_inc(32'(hits), CNT_W));
        end else begin
          misses <= CNT_W'(sat_inc(32'(misses), CNT_W));
        end
      end
    end
  end

endmodule

// File: rtl/dance_judge_multi.sv
// Multi-player judging core: game FSM, arrow window and beat counter,
// with one dance_lane_judge slice per player.
module dance_judge_multi
  import dance_pkg::*;
#(
  parameter int          NUM_PLAYERS = 2,
  parameter int          NUM_LANES   = 4,
  parameter int          CNT_W       = 16,
  parameter int unsigned MAX_BEATS   = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic                             beat,
  input  logic [NUM_LANES-1:0]             target,
  input  logic [NUM_PLAYERS*NUM_LANES-1:0] btn,
  output logic [NUM_PLAYERS*CNT_W-1:0]     hits,
  output logic [NUM_PLAYERS*CNT_W-1:0]     misses,
  output logic [NUM_PLAYERS*CNT_W-1:0]     errorpress,
  output logic [1:0]                       state,
  output logic                             game_over
);

  state_t               state_q;
  logic [NUM_LANES-1:0] window;
  logic [CNT_W-1:0]     beat_cnt;
  logic                 judge;
  logic                 close;
  logic                 last_beat;
  logic                 load;

  assign judge     = enable && (state_q == JUDGE);
  assign close     = judge && beat;
  assign last_beat = (MAX_BEATS != 0) && (32'(beat_cnt) == MAX_BEATS);
  assign load      = enable && beat &&
                     ((state_q == ARMED) || ((state_q == JUDGE) && !last_beat));
  assign state     = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      game_over <= 1'b0;
      window    <= '0;
      beat_cnt  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) state_q <= ARMED;
        end
        ARMED: begin
          if (!enable) begin
            state_q <= IDLE;
          end else if (beat) begin
            state_q  <= JUDGE;
            window   <= target;
            beat_cnt <= CNT_W'(1);
          end
        end
        JUDGE: begin
          // Dropping enable abandons the open window without scoring it.
          if (!enable) begin
            state_q <= IDLE;
            window  <= '0;
          end else if (beat) begin
            if (last_beat) begin
              state_q   <= DONE;
              game_over <= 1'b1;
            end else begin
              window   <= target;
              beat_cnt <= CNT_W'(sat_inc(32'(beat_cnt), CNT_W));
            end
          end
        end
        DONE: begin
          if (!enable) begin
            state_q   <= IDLE;
            game_over <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    dance_lane_judge #(
      .NUM_LANES (NUM_LANES),
      .CNT_W     (CNT_W)
    ) u_judge (
      .clk        (clk),
      .rst        (rst),
      .judge      (judge),
      .close      (close),
      .load       (load),
      .window     (window),
      .btn        (btn[p*NUM_LANES +: NUM_LANES]),
      .hits       (hits[p*CNT_W +: CNT_W]),
      .misses     (misses[p*CNT_W +: CNT_W]),
      .errorpress (errorpress[p*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_dance_judge_multi.sv
// Self-checking bench for dance_judge_multi: directed game scenarios followed
// by random play, all compared against a beat-level scoring model.
module tb_dance_judge_multi;

  localparam int NP  = 2;
  localparam int NL  = 4;
  localparam int CW  = 4;
  localparam int MB  = 3;
  localparam int SAT = (1 << CW) - 1;

  logic              clk;
  logic              rst;
  logic              enable;
  logic              beat;
  logic [NL-1:0]     target;
  logic [NP*NL-1:0]  btn;
  logic [NP*CW-1:0]  hits;
  logic [NP*CW-1:0]  misses;
  logic [NP*CW-1:0]  errorpress;
  logic [1:0]        state;
  logic              game_over;

  int compared;
  int mismatched;

  // Reference model: game phase, the current arrow set, which arrows each
  // player has already struck, and the score tallies.
  int          m_state;
  int          m_beats;
  bit [NL-1:0] m_window;
  bit          m_got [NP][NL];
  bit [NP*NL-1:0] m_prev;
  int          m_hits [NP];
  int          m_miss [NP];
  int          m_err  [NP];

  dance_judge_multi #(
    .NUM_PLAYERS (NP),
    .NUM_LANES   (NL),
    .CNT_W       (CW),
    .MAX_BEATS   (MB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .beat       (beat),
    .target     (target),
    .btn        (btn),
    .hits       (hits),
    .misses     (misses),
    .errorpress (errorpress),
    .state      (state),
    .game_over  (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int satInc(input int v);
    return (v < SAT) ? v + 1 : v;
  endfunction

  task automatic modelStep(input bit r, input bit en, input bit bt,
                           input bit [NL-1:0] tgt, input bit [NP*NL-1:0] b);
    bit [NP*NL-1:0] pr;
    bit any_err;
    bit all_hit;
    if (r) begin
      m_state  = 0;
      m_beats  = 0;
      m_window = '0;
      m_prev   = '1;
      for (int p = 0; p < NP; p++) begin
        m_hits[p] = 0;
        m_miss[p] = 0;
        m_err[p]  = 0;
        for (int l = 0; l < NL; l++) m_got[p][l] = 1'b0;
      end
      return;
    end
    pr = b & ~m_prev;
    if (m_state == 2 && en) begin
      for (int p = 0; p < NP; p++) begin
        any_err = 1'b0;
        for (int l = 0; l < NL; l++) begin
          if (pr[p*NL+l]) begin
            if (m_window[l] && !m_got[p][l]) m_got[p][l] = 1'b1;
            else any_err = 1'b1;
          end
        end
        if (any_err) m_err[p] = satInc(m_err[p]);
        if (bt && m_window != '0) begin
          all_hit = 1'b1;
          for (int l = 0; l < NL; l++)
            if (m_window[l] && !m_got[p][l]) all_hit = 1'b0;
          if (all_hit) m_hits[p] = satInc(m_hits[p]);
          else m_miss[p] = satInc(m_miss[p]);
        end
      end
    end
    m_prev = b;
    case (m_state)
      0: if (en) m_state = 1;
      1: begin
        if (!en) m_state = 0;
        else if (bt) begin
          m_state  = 2;
          m_window = tgt;
          m_beats  = 1;
          for (int p = 0; p < NP; p++)
            for (int l = 0; l < NL; l++) m_got[p][l] = 1'b0;
        end
      end
      2: begin
        if (!en) m_state = 0;
        else if (bt) begin
          if (m_beats == MB) m_state = 3;
          else begin
            m_window = tgt;
            m_beats  = m_beats + 1;
            for (int p = 0; p < NP; p++)
              for (int l = 0; l < NL; l++) m_got[p][l] = 1'b0;
          end
        end
      end
      default: if (!en) m_state = 0;
    endcase
  endtask

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkOne("state", 32'(state), 32'(m_state));
    checkOne("game_over", 32'(game_over), (m_state == 3) ? 32'd1 : 32'd0);
    for (int p = 0; p < NP; p++) begin
      checkOne($sformatf("hits%0d", p), 32'(hits[p*CW +: CW]), 32'(m_hits[p]));
      checkOne($sformatf("misses%0d", p), 32'(misses[p*CW +: CW]), 32'(m_miss[p]));
      checkOne($sformatf("errorpress%0d", p), 32'(errorpress[p*CW +: CW]), 32'(m_err[p]));
    end
  endtask

  // One clock of stimulus: drive on the falling edge, step the model,
  // then compare just after the rising edge.
  task automatic applyStimulus(input bit r, input bit en, input bit bt,
                               input bit [NL-1:0] tgt, input bit [NP*NL-1:0] b);
    @(negedge clk);
    rst    = r;
    enable = en;
    beat   = bt;
    target = tgt;
    btn    = b;
    modelStep(r, en, bt, tgt, b);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst    = 1'b1;
    enable = 1'b0;
    beat   = 1'b0;
    target = '0;
    btn    = '1;

    // Buttons held through reset must never look like presses.
    repeat (3) applyStimulus(1, 0, 0, 4'b0000, 8'hFF);
    checkOne("reset_state", 32'(state), 32'd0);
    checkOne("reset_err0", 32'(errorpress[0 +: CW]), 32'd0);
    applyStimulus(0, 1, 0, 4'b0000, 8'hFF);
    applyStimulus(0, 1, 1, 4'b0100, 8'hFF);
    repeat (3) applyStimulus(0, 1, 0, 4'b0000, 8'hFF);
    checkOne("held_err0", 32'(errorpress[0 +: CW]), 32'd0);
    applyStimulus(0, 1, 0, 4'b0000, 8'h00);

    // Perfect hit for player 0 on 1001, player 1 idle.
    applyStimulus(0, 1, 1, 4'b1001, 8'h00);
    applyStimulus(0, 1, 0, 4'b0000, 8'h01);
    applyStimulus(0, 1, 0, 4'b0000, 8'h09);
    applyStimulus(0, 1, 0, 4'b0000, 8'h00);

    // Duplicate and wrong-lane presses; two wrong lanes in one cycle count once.
    applyStimulus(0, 1, 1, 4'b0010, 8'h00);
    checkOne("perfect_hits0", 32'(hits[0 +: CW]), 32'd1);
    applyStimulus(0, 1, 0, 4'b0000, 8'h02);
    applyStimulus(0, 1, 0, 4'b0000, 8'h00);
    applyStimulus(0, 1, 0, 4'b0000, 8'h02);
    applyStimulus(0, 1, 0, 4'b0000, 8'h00);
    applyStimulus(0, 1, 0, 4'b0000, 8'h04);
    applyStimulus(0, 1, 0, 4'b0000, 8'h00);
    applyStimulus(0, 1, 0, 4'b0000, 8'h0C);
    checkOne("errors_err0", 32'(errorpress[0 +: CW]), 32'd3);
    applyStimulus(0, 1, 0, 4'b0000, 8'h00);

    // Third beat ends the game; presses in DONE change nothing.
    applyStimulus(0, 1, 1, 4'b0001, 8'h00);
    checkOne("done_game_over", 32'(game_over), 32'd1);
    applyStimulus(0, 1, 0, 4'b0000, 8'hFF);
    applyStimulus(0, 1, 1, 4'b1111, 8'h00);
    applyStimulus(0, 0, 0, 4'b0000, 8'h00);

    // New game: player 1 strikes lane 1 on the very beat that closes the window.
    applyStimulus(0, 1, 0, 4'b0000, 8'h00);
    applyStimulus(0, 1, 1, 4'b0010, 8'h00);
    applyStimulus(0, 1, 1, 4'b0001, 8'h20);
    applyStimulus(0, 1, 0, 4'b0000, 8'h00);

    // Enable drops with the window unhit: no miss is scored.
    applyStimulus(0, 0, 0, 4'b0000, 8'h00);
    applyStimulus(0, 0, 0, 4'b0000, 8'h00);

    // Saturation of the error counter inside an empty window.
    applyStimulus(0, 1, 0, 4'b0000, 8'h00);
    applyStimulus(0, 1, 1, 4'b0000, 8'h00);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 0, 4'b0000, 8'h01);
      applyStimulus(0, 1, 0, 4'b0000, 8'h00);
    end
    checkOne("sat_err0", 32'(errorpress[0 +: CW]), 32'd15);

    // Random play, including occasional mid-game resets.
    applyStimulus(1, 0, 0, 4'b0000, 8'h00);
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 99) == 0,
                    $urandom_range(0, 15) != 0,
                    $urandom_range(0, 3) == 0,
                    NL'($urandom),
                    (NP*NL)'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
